noc_phase_sequencer: RTL and testbench

NOC_PHASE_SEQUENCER -- requirements
Module: noc_phase_sequencer

---
 rtl/noc_phase_sequencer_pkg.sv | 27 ++
 rtl/noc_op_fanout.sv | 38 +++
 rtl/noc_phase_sequencer.sv | 96 +++++++++
 tb/tb_noc_phase_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_phase_sequencer_pkg.sv
// Shared op codes and sequencer state encoding for the NoC phase sequencer,
// routers and traffic generators.
package noc_phase_sequencer_pkg;

  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_LOAD_RT      = 3'd1;
  localparam logic [2:0] OP_LOAD_STAGING = 3'd2;
  localparam logic [2:0] OP_PHASE0       = 3'd3;
  localparam logic [2:0] OP_PHASE1       = 3'd4;
  localparam logic [2:0] OP_INIT         = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_TRAFFIC = 3'd1,
    S_INIT         = 3'd2,
    S_LOAD_RT      = 3'd3,
    S_LOAD_STAGING = 3'd4,
    S_PHASE0       = 3'd5,
    S_PHASE1       = 3'd6,
    S_DONE         = 3'd7
  } state_t;

  function automatic logic state_is_busy(state_t s);
    return !((s == S_IDLE) || (s == S_DONE));
  endfunction

endpackage

// File: rtl/noc_op_fanout.sv
// Combinational decode of the sequencer state (plus rt_valid and hold)
// into one op code per router, packed router i at [i*OP_SIZE +: OP_SIZE].
module noc_op_fanout
  import noc_phase_sequencer_pkg::*;
#(
  parameter int ROUTER_SIZE = 16,
  parameter int OP_SIZE     = 4
) (
  input  logic [2:0]                     i_state,
  input  logic [ROUTER_SIZE-1:0]         i_rt_valid,
  input  logic                           i_hold,
  output logic [ROUTER_SIZE*OP_SIZE-1:0] o_router_op
);

  state_t w_state;

  assign w_state = state_t'(i_state);

  always_comb begin
    o_router_op = '0;
    for (int i = 0; i < ROUTER_SIZE; i++) begin
      case (w_state)
        S_INIT:         o_router_op[i*OP_SIZE +: OP_SIZE] = OP_SIZE'(OP_INIT);
        S_LOAD_RT: begin
          if (i_rt_valid[i]) o_router_op[i*OP_SIZE +: OP_SIZE] = OP_SIZE'(OP_LOAD_RT);
        end
        // A held staging cycle stalls every router with NOP.
        S_LOAD_STAGING: begin
          if (!i_hold) o_router_op[i*OP_SIZE +: OP_SIZE] = OP_SIZE'(OP_LOAD_STAGING);
        end
        S_PHASE0:       o_router_op[i*OP_SIZE +: OP_SIZE] = OP_SIZE'(OP_PHASE0);
        S_PHASE1:       o_router_op[i*OP_SIZE +: OP_SIZE] = OP_SIZE'(OP_PHASE1);
        default:        o_router_op[i*OP_SIZE +: OP_SIZE] = OP_SIZE'(OP_NOP);
      endcase
    end
  end

endmodule

// File: rtl/noc_phase_sequencer.sv
// Sequences a NoC simulation: wait for traffic, init routers, load routing
// tables, then run max_cycle simulated cycles of staging/phase0/phase1.
module noc_phase_sequencer
  import noc_phase_sequencer_pkg::*;
#(
  parameter int ROUTER_SIZE = 16,
  parameter int CYCLE_BITS  = 32,
  parameter int OP_SIZE     = 4,
  localparam int DST_W      = (ROUTER_SIZE > 1) ? $clog2(ROUTER_SIZE) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CYCLE_BITS-1:0]          max_cycle,
  input  logic                           traffic_ready,
  input  logic [ROUTER_SIZE-1:0]         rt_valid,
  input  logic                           hold,
  output logic [ROUTER_SIZE*OP_SIZE-1:0] router_op,
  output logic [DST_W-1:0]               rt_dst,
  output logic [CYCLE_BITS-1:0]          in_cycle,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     dbg_state
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CYCLE_BITS-1:0] r_max_cycle;
  logic [CYCLE_BITS-1:0] r_in_cycle;
  logic [DST_W-1:0]      r_rt_dst;
  logic [CYCLE_BITS-1:0] w_in_cycle_inc;
  logic                  w_rt_last;
  logic                  w_run_last;
  logic                  w_accept;

  assign w_accept       = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_rt_last      = (r_rt_dst == DST_W'(ROUTER_SIZE - 1));
  // in_cycle < max_cycle whenever PHASE1 is reached, so the increment never wraps.
  assign w_in_cycle_inc = r_in_cycle + CYCLE_BITS'(1);
  assign w_run_last     = (w_in_cycle_inc == r_max_cycle);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE:  if (start) w_state_nxt = S_WAIT_TRAFFIC;
      S_WAIT_TRAFFIC:  if (traffic_ready) w_state_nxt = S_INIT;
      S_INIT:          w_state_nxt = S_LOAD_RT;
      S_LOAD_RT: begin
        if (w_rt_last) w_state_nxt = (r_max_cycle == '0) ? S_DONE : S_LOAD_STAGING;
      end
      S_LOAD_STAGING:  if (!hold) w_state_nxt = S_PHASE0;
      S_PHASE0:        w_state_nxt = S_PHASE1;
      S_PHASE1:        w_state_nxt = w_run_last ? S_DONE : S_LOAD_STAGING;
      default:         w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_max_cycle <= '0;
      r_in_cycle  <= '0;
      r_rt_dst    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_max_cycle <= max_cycle;
        r_in_cycle  <= '0;
        r_rt_dst    <= '0;
      end
      if (r_state == S_LOAD_RT) begin
        r_rt_dst <= w_rt_last ? '0 : r_rt_dst + DST_W'(1);
      end
      if (r_state == S_PHASE1) begin
        r_in_cycle <= w_in_cycle_inc;
      end
    end
  end

  noc_op_fanout #(
    .ROUTER_SIZE (ROUTER_SIZE),
    .OP_SIZE     (OP_SIZE)
  ) u_fanout (
    .i_state     (r_state),
    .i_rt_valid  (rt_valid),
    .i_hold      (hold),
    .o_router_op (router_op)
  );

  assign rt_dst    = r_rt_dst;
  assign in_cycle  = r_in_cycle;
  assign busy      = state_is_busy(r_state);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// Bench for noc_phase_sequencer with 4 routers and an 8-bit cycle counter:
// per-cycle vector tables plus hand sequences for long runs and mid-run reset.
module tb_noc_phase_sequencer;
  import noc_phase_sequencer_pkg::*;

  localparam int RS = 4;
  localparam int CB = 8;
  localparam int OS = 4;
  localparam int OW = RS * OS;
  localparam int EW = OW + 2 + CB + 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CB-1:0] max_cycle;
  logic          traffic_ready;
  logic [RS-1:0] rt_valid;
  logic          hold;
  logic [OW-1:0] router_op;
  logic [1:0]    rt_dst;
  logic [CB-1:0] in_cycle;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  noc_phase_sequencer #(
    .ROUTER_SIZE (RS),
    .CYCLE_BITS  (CB),
    .OP_SIZE     (OS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .max_cycle     (max_cycle),
    .traffic_ready (traffic_ready),
    .rt_valid      (rt_valid),
    .hold          (hold),
    .router_op     (router_op),
    .rt_dst        (rt_dst),
    .in_cycle      (in_cycle),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          start;
    logic [CB-1:0] max_cycle;
    logic          traffic_ready;
    logic          hold;
    logic [RS-1:0] rt_valid;
    logic [OW-1:0] op;
    logic [1:0]    dst;
    logic [CB-1:0] inc;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t          vecs[$];
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic [OW-1:0] all_op(input logic [3:0] c);
    return {c, c, c, c};
  endfunction

  function automatic logic [OW-1:0] rt_op(input logic [RS-1:0] m);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < RS; i++) if (m[i]) r[i*OS +: OS] = 4'd1;
    return r;
  endfunction

  task automatic add(input logic st, input logic [CB-1:0] mc, input logic tr, input logic hd,
                     input logic [RS-1:0] rv, input logic [OW-1:0] op, input logic [1:0] dst,
                     input logic [CB-1:0] inc, input logic bz, input logic dn);
    vec_t v;
    v = '{st, mc, tr, hd, rv, op, dst, inc, bz, dn};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // scoreboard: pop the expected output word and compare to the DUT
  task automatic sb_compare(input string name, input int idx);
    logic [EW-1:0] exp;
    logic [EW-1:0] act;
    exp = exp_q.pop_front();
    act = {router_op, rt_dst, in_cycle, busy, done};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got op=%h dst=%0d inc=%0d busy=%b done=%b, expected op=%h dst=%0d inc=%0d busy=%b done=%b",
                  name, idx, act[EW-1 -: OW], act[CB+3:CB+2], act[CB+1:2], act[1], act[0],
                  exp[EW-1 -: OW], exp[CB+3:CB+2], exp[CB+1:2], exp[1], exp[0]);
  endtask

  task automatic run_rows(input string name, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      tick();
      start         = vecs[i].start;
      max_cycle     = vecs[i].max_cycle;
      traffic_ready = vecs[i].traffic_ready;
      hold          = vecs[i].hold;
      rt_valid      = vecs[i].rt_valid;
      exp_q.push_back({vecs[i].op, vecs[i].dst, vecs[i].inc, vecs[i].busy, vecs[i].done});
      #3;
      sb_compare(name, i - lo);
    end
  endtask

  int t1_lo, t1_hi, t2_lo, t2_hi, t3_lo, t3_hi;

  initial begin
    int n;
    int wrapped;
    logic [CB-1:0] prev;

    // table 1: max_cycle=2, all routers have routes
    t1_lo = vecs.size();
    add(1, 2, 1, 0, 4'hF, '0,        0, 0, 0, 0);
    add(0, 2, 1, 0, 4'hF, '0,        0, 0, 1, 0);
    add(0, 2, 1, 0, 4'hF, all_op(5), 0, 0, 1, 0);
    for (int d = 0; d < 4; d++) add(0, 2, 1, 0, 4'hF, all_op(1), 2'(d), 0, 1, 0);
    for (int c = 0; c < 2; c++) begin
      add(0, 2, 1, 0, 4'hF, all_op(2), 0, 8'(c), 1, 0);
      add(0, 2, 1, 0, 4'hF, all_op(3), 0, 8'(c), 1, 0);
      add(0, 2, 1, 0, 4'hF, all_op(4), 0, 8'(c), 1, 0);
    end
    add(0, 2, 1, 0, 4'hF, '0, 0, 2, 0, 1);
    t1_hi = vecs.size();

    // table 2: partial routes, late traffic, stalled staging, ignored start/max/hold
    t2_lo = vecs.size();
    add(1, 1, 0, 0, 4'h5, '0, 0, 2, 0, 1);
    add(1, 7, 0, 0, 4'h5, '0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 7, 0, 0, 4'h5, '0, 0, 0, 1, 0);
    add(0, 7, 1, 0, 4'h5, '0,        0, 0, 1, 0);
    add(0, 7, 0, 0, 4'h5, all_op(5), 0, 0, 1, 0);
    for (int d = 0; d < 4; d++) add(0, 7, 0, 1, 4'h5, rt_op(4'h5), 2'(d), 0, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 7, 0, 1, 4'h5, '0, 0, 0, 1, 0);
    add(0, 7, 0, 0, 4'h5, all_op(2), 0, 0, 1, 0);
    add(0, 7, 0, 1, 4'h5, all_op(3), 0, 0, 1, 0);
    add(0, 7, 0, 1, 4'h5, all_op(4), 0, 0, 1, 0);
    add(0, 7, 0, 0, 4'h5, '0,        0, 1, 0, 1);
    t2_hi = vecs.size();

    // table 3: max_cycle=0 goes straight to DONE after the routing load
    t3_lo = vecs.size();
    add(1, 0, 1, 0, 4'hF, '0,        0, 1, 0, 1);
    add(0, 0, 1, 0, 4'hF, '0,        0, 0, 1, 0);
    add(0, 0, 1, 0, 4'hF, all_op(5), 0, 0, 1, 0);
    for (int d = 0; d < 4; d++) add(0, 0, 1, 0, 4'hF, all_op(1), 2'(d), 0, 1, 0);
    add(0, 0, 1, 0, 4'hF, '0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 4'hF, '0, 0, 0, 0, 1);
    t3_hi = vecs.size();

    rst_n = 1'b0; start = 1'b0; max_cycle = '0; traffic_ready = 1'b0;
    rt_valid = '0; hold = 1'b0;
    #2;
    chk("reset_op",    32'(router_op), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));
    chk("reset_flags", {30'd0, busy, done}, 32'h0);
    #10 rst_n = 1'b1;

    run_rows("table_basic", t1_lo, t1_hi);
    run_rows("table_stall", t2_lo, t2_hi);
    run_rows("table_zero",  t3_lo, t3_hi);

    // max_cycle = 255: full-range run, counter must stop at 255 without wrapping
    tick();
    start = 1; max_cycle = 8'd255; traffic_ready = 1; hold = 0; rt_valid = 4'hF;
    tick();
    start = 0; max_cycle = 8'd3;
    n = 1; wrapped = 0; prev = 0;
    #3;
    while (!done && n < 2000) begin
      tick();
      n++;
      #3;
      if (in_cycle < prev) wrapped = 1;
      prev = in_cycle;
    end
    chk("max255_clocks",  32'(n), 32'd772);
    chk("max255_in_cycle", 32'(in_cycle), 32'd255);
    chk("max255_no_wrap", 32'(wrapped), 32'd0);
    repeat (3) tick();
    #3;
    chk("max255_hold_done", {23'd0, in_cycle, done}, {23'd0, 8'd255, 1'b1});

    // asynchronous reset in the second PHASE0 of a max_cycle=2 run
    tick();
    start = 1; max_cycle = 8'd2;
    tick();
    start = 0;
    repeat (10) tick();
    #1;
    chk("pre_reset_phase0", 32'(router_op), 32'(all_op(3)));
    chk("pre_reset_in_cycle", 32'(in_cycle), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_op",    32'(router_op), 32'h0);
    chk("async_reset_state", 32'(dbg_state), 32'(S_IDLE));
    chk("async_reset_regs",  {22'd0, rt_dst, in_cycle, busy, done}, 32'h0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    run_rows("table_after_reset", t1_lo, t1_hi);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
